// File: rtl/universal_shift_register_n_bit.sv
// Universal N-bit shift register with manual per-clock operation and an
// automatic burst mode (Busy/Done handshake). State updates on the falling
// clock edge; asynchronous active-high reset.
module universal_shift_register_n_bit #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic             Clk_In,
    input  logic             Reset_In,
    input  logic             Enable_In,
    input  logic [2:0]       Mode_In,
    input  logic             Start_In,
    input  logic [CNT_W-1:0] Shift_Count_In,
    input  logic             Serial_Left_In,
    input  logic             Serial_Right_In,
    input  logic [WIDTH-1:0] Parallel_Data_In,
    output logic [WIDTH-1:0] Parallel_Data_Out,
    output logic             Serial_Left_Out,
    output logic             Serial_Right_Out,
    output logic             Busy_Out,
    output logic             Done_Out
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         mode_q, mode_d;
    logic               start_burst;

    // One register operation for the given mode.
    function automatic logic [WIDTH-1:0] apply_mode(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] d,
        input logic             sl,
        input logic             sr,
        input logic [WIDTH-1:0] pd
    );
        logic [WIDTH-1:0] r;
        r = d;
        case (m)
            3'b001:  r = {d[WIDTH-2:0], sr};
            3'b010:  r = {sl, d[WIDTH-1:1]};
            3'b011:  r = {d[WIDTH-2:0], d[WIDTH-1]};
            3'b100:  r = {d[0], d[WIDTH-1:1]};
            3'b101:  r = pd;
            3'b110:  r = '0;
            default: r = d;
        endcase
        return r;
    endfunction

    // A burst is only accepted for shift/rotate modes.
    assign start_burst = Start_In && (Mode_In inside {[3'b001:3'b100]});

    // Next-state, next-register and counter logic.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (start_burst) begin
                    mode_d = Mode_In;
                    cnt_d  = Shift_Count_In;
                    state_d = (Shift_Count_In == '0) ? DONE : BUSY;
                end else begin
                    data_d = apply_mode(Mode_In, data_q, Serial_Left_In,
                                        Serial_Right_In, Parallel_Data_In);
                end
            end
            BUSY: begin
                data_d = apply_mode(mode_q, data_q, Serial_Left_In,
                                    Serial_Right_In, Parallel_Data_In);
                cnt_d  = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; Enable_In low freezes everything.
    always_ff @(negedge Clk_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            mode_q  <= '0;
        end else if (Enable_In) begin
            state_q <= state_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

    assign Parallel_Data_Out = data_q;
    assign Busy_Out          = (state_q == BUSY);
    assign Done_Out          = (state_q == DONE);
    assign Serial_Left_Out   = Enable_In ? data_q[WIDTH-1] : 1'bz;
    assign Serial_Right_Out  = Enable_In ? data_q[0]       : 1'bz;

endmodule

// File: tb/tb_universal_shift_register_n_bit.sv
// Scoreboard bench for universal_shift_register_n_bit (WIDTH=8, CNT_W=4).
// Stimulus pushes the expected post-edge state; a monitor on the rising
// edge (opposite to the active falling edge) pops and compares.
module tb_universal_shift_register_n_bit;

    logic       clk = 1'b0;
    logic       Reset_In = 1'b1;
    logic       Enable_In = 1'b1;
    logic [2:0] Mode_In = 3'b000;
    logic       Start_In = 1'b0;
    logic [3:0] Shift_Count_In = 4'd0;
    logic       Serial_Left_In = 1'b0;
    logic       Serial_Right_In = 1'b0;
    logic [7:0] Parallel_Data_In = 8'h00;
    logic [7:0] Parallel_Data_Out;
    logic       Serial_Left_Out;
    logic       Serial_Right_Out;
    logic       Busy_Out;
    logic       Done_Out;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    typedef struct {
        string      nm;
        logic [7:0] r;
        logic       b;
        logic       d;
        logic       chk_ser;
    } exp_t;

    exp_t q[$];

    universal_shift_register_n_bit #(
        .WIDTH(8),
        .CNT_W(4)
    ) dut (
        .Clk_In           (clk),
        .Reset_In         (Reset_In),
        .Enable_In        (Enable_In),
        .Mode_In          (Mode_In),
        .Start_In         (Start_In),
        .Shift_Count_In   (Shift_Count_In),
        .Serial_Left_In   (Serial_Left_In),
        .Serial_Right_In  (Serial_Right_In),
        .Parallel_Data_In (Parallel_Data_In),
        .Parallel_Data_Out(Parallel_Data_Out),
        .Serial_Left_Out  (Serial_Left_Out),
        .Serial_Right_Out (Serial_Right_Out),
        .Busy_Out         (Busy_Out),
        .Done_Out         (Done_Out)
    );

    always #5 clk = ~clk;

    // Monitor: compare the state produced by the preceding falling edge.
    always @(posedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic ok;
            e  = q.pop_front();
            ok = (Parallel_Data_Out === e.r) && (Busy_Out === e.b) && (Done_Out === e.d);
            if (e.chk_ser)
                ok = ok && (Serial_Left_Out === e.r[7]) && (Serial_Right_Out === e.r[0]);
            n_tests++;
            if (!ok) begin
                n_fail++;
                $display("FAIL %s: got reg=%h busy=%b done=%b sl=%b sr=%b, expected reg=%h busy=%b done=%b",
                         e.nm, Parallel_Data_Out, Busy_Out, Done_Out, Serial_Left_Out,
                         Serial_Right_Out, e.r, e.b, e.d);
            end
        end
    end

    // rl: 0 = reset low, 1 = reset held across the edge, 2 = short pulse
    // well before the falling edge (proves asynchronous action).
    task automatic cyc(input string nm, input int rl, input logic en, input logic [2:0] md,
                       input logic st, input logic [3:0] cn, input logic sli, input logic sri,
                       input logic [7:0] pd, input logic [7:0] er, input logic eb, input logic ed);
        exp_t e;
        @(posedge clk);
        #1;
        Enable_In        = en;
        Mode_In          = md;
        Start_In         = st;
        Shift_Count_In   = cn;
        Serial_Left_In   = sli;
        Serial_Right_In  = sri;
        Parallel_Data_In = pd;
        Reset_In         = (rl == 1);
        if (rl == 2) begin
            Reset_In = 1'b1;
            #1;
            Reset_In = 1'b0;
        end
        e.nm = nm; e.r = er; e.b = eb; e.d = ed; e.chk_ser = en;
        q.push_back(e);
    endtask

    initial begin
        // Reset dominates a load request
        cyc("reset_hold",   1, 1, 3'b101, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
        // Async reset with enable low at the edge: only the async path can clear
        cyc("load_A5",      0, 1, 3'b101, 0, 0, 0, 0, 8'hA5, 8'hA5, 0, 0);
        cyc("async_rst_A5", 2, 0, 3'b101, 0, 0, 0, 0, 8'hFF, 8'h00, 0, 0);
        // Manual modes
        cyc("load_81",      0, 1, 3'b101, 0, 0, 0, 0, 8'h81, 8'h81, 0, 0);
        cyc("shl_sr1",      0, 1, 3'b001, 0, 0, 0, 1, 8'h00, 8'h03, 0, 0);
        cyc("shr_sl0",      0, 1, 3'b010, 0, 0, 0, 1, 8'h00, 8'h01, 0, 0);
        cyc("hold_000",     0, 1, 3'b000, 0, 0, 1, 1, 8'hFF, 8'h01, 0, 0);
        cyc("hold_111",     0, 1, 3'b111, 0, 0, 1, 1, 8'hFF, 8'h01, 0, 0);
        cyc("shr_sl1",      0, 1, 3'b010, 0, 0, 1, 0, 8'h00, 8'h80, 0, 0);
        cyc("clear",        0, 1, 3'b110, 0, 0, 1, 1, 8'hFF, 8'h00, 0, 0);
        // Burst rotate left x3 from 0x96; inputs during BUSY/DONE must be ignored
        cyc("load_96",      0, 1, 3'b101, 0, 0, 0, 0, 8'h96, 8'h96, 0, 0);
        cyc("rol_start",    0, 1, 3'b011, 1, 3, 0, 0, 8'h00, 8'h96, 1, 0);
        cyc("rol_s1",       0, 1, 3'b110, 1, 9, 1, 1, 8'hFF, 8'h2D, 1, 0);
        cyc("rol_s2",       0, 1, 3'b101, 0, 0, 1, 1, 8'hFF, 8'h5A, 1, 0);
        cyc("rol_s3_done",  0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'hB4, 0, 1);
        cyc("rol_idle",     0, 1, 3'b001, 1, 2, 0, 1, 8'h00, 8'hB4, 0, 0);
        cyc("idle_hold",    0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'hB4, 0, 0);
        // Burst rotate right x4 from 0x01 with a two-edge enable pause
        cyc("load_01",      0, 1, 3'b101, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0);
        cyc("ror_start",    0, 1, 3'b100, 1, 4, 0, 0, 8'h00, 8'h01, 1, 0);
        cyc("ror_s1",       0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h80, 1, 0);
        cyc("ror_s2",       0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h40, 1, 0);
        cyc("ror_pause1",   0, 0, 3'b110, 1, 1, 1, 1, 8'hFF, 8'h40, 1, 0);
        cyc("ror_pause2",   0, 0, 3'b101, 1, 1, 1, 1, 8'hFF, 8'h40, 1, 0);
        cyc("ror_s3",       0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h20, 1, 0);
        cyc("ror_s4_done",  0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h10, 0, 1);
        cyc("ror_idle",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0);
        // Count zero: straight to DONE, register untouched
        cyc("cnt0_start",   0, 1, 3'b001, 1, 0, 1, 1, 8'h00, 8'h10, 0, 1);
        cyc("cnt0_idle",    0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h10, 0, 0);
        // Start with load mode: treated as manual load
        cyc("start_load",   0, 1, 3'b101, 1, 5, 0, 0, 8'h3C, 8'h3C, 0, 0);
        cyc("start_load_h", 0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h3C, 0, 0);
        // Reset mid-burst aborts with no Done
        cyc("shl5_start",   0, 1, 3'b001, 1, 5, 0, 0, 8'h00, 8'h3C, 1, 0);
        cyc("shl5_s1",      0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h78, 1, 0);
        cyc("shl5_s2",      0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'hF0, 1, 0);
        cyc("rst_busy",     2, 0, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        cyc("post_rst",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0);
        // Full burst after reset; serial input sampled live per step
        cyc("load_01b",     0, 1, 3'b101, 0, 0, 0, 0, 8'h01, 8'h01, 0, 0);
        cyc("shl5b_start",  0, 1, 3'b001, 1, 5, 0, 0, 8'h00, 8'h01, 1, 0);
        cyc("shl5b_s1",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h02, 1, 0);
        cyc("shl5b_s2",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h04, 1, 0);
        cyc("shl5b_s3",     0, 1, 3'b000, 0, 0, 0, 1, 8'h00, 8'h09, 1, 0);
        cyc("shl5b_s4",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h12, 1, 0);
        cyc("shl5b_s5",     0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h24, 0, 1);
        cyc("shl5b_idle",   0, 1, 3'b000, 0, 0, 0, 0, 8'h00, 8'h24, 0, 0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 5 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
        end
        if (q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending entries, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
